// File: rtl/mgmt_irq_arbiter.sv
// +----------------------------------------------------------------------------+
// | mgmt_irq_arbiter                                                           |
// | Vectored interrupt controller for the management CPU: synchronize, qualify,|
// | mask, arbitrate, hold in service until EOI. Optional IRQ_RR_ARB_EN macro.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mgmt_irq_arbiter #(
    parameter int NSRC        = 8,
    parameter int IDW         = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic            core_clk,
    input  logic            core_rstn,
    input  logic [NSRC-1:0] irq_src,
    input  logic            csr_we,
    input  logic            csr_re,
    input  logic [2:0]      csr_addr,
    input  logic [31:0]     csr_wdata,
    output logic [31:0]     csr_rdata,
    output logic            irq_valid,
    output logic [IDW-1:0]  irq_id,
    input  logic            irq_ack
);

    localparam logic [2:0] ADDR_ENABLE   = 3'd0;
    localparam logic [2:0] ADDR_MODE     = 3'd1;
    localparam logic [2:0] ADDR_POLARITY = 3'd2;
    localparam logic [2:0] ADDR_PENDING  = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_EOI      = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [IDW-1:0]  id_next;
    logic [NSRC-1:0] sync_q [SYNC_STAGES];
    logic [NSRC-1:0] src_qual;
    logic [NSRC-1:0] src_hist;
    logic [NSRC-1:0] enable, mode, polarity, pending;
    logic [NSRC-1:0] pending_next, rise, w1c, ack_clr, eligible;
    logic [IDW-1:0]  winner;
    logic            any_eligible, ack_fire, eoi_hit;
    logic [31:0]     rdata_next;
    logic            unused_wdata;

    assign unused_wdata = ^csr_wdata;

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            src_qual <= '0;
            src_hist <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            src_qual <= sync_q[SYNC_STAGES-1] ^ polarity;
            src_hist <= src_qual;
        end
    end

    // Edge bits: a new rising edge beats any clear in the same cycle.
    assign rise     = src_qual & ~src_hist;
    assign w1c      = (csr_we && csr_addr == ADDR_PENDING) ? csr_wdata[NSRC-1:0] : '0;
    assign ack_fire = (state == ST_REQ) && eligible[irq_id] && irq_ack;
    assign ack_clr  = ack_fire ? (NSRC'(1) << irq_id) : '0;
    assign eoi_hit  = (state == ST_SVC) && csr_we && (csr_addr == ADDR_EOI) &&
                      (csr_wdata[IDW-1:0] == irq_id);

    assign pending_next = (mode & (rise | (pending & ~(w1c | ack_clr)))) |
                          (~mode & src_qual);
    assign eligible     = pending & enable;
    assign any_eligible = |eligible;

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            enable   <= '0;
            mode     <= '0;
            polarity <= '0;
            pending  <= '0;
        end else begin
            pending <= pending_next;
            if (csr_we) begin
                case (csr_addr)
                    ADDR_ENABLE:   enable   <= csr_wdata[NSRC-1:0];
                    ADDR_MODE:     mode     <= csr_wdata[NSRC-1:0];
                    ADDR_POLARITY: polarity <= csr_wdata[NSRC-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef IRQ_RR_ARB_EN
    logic [IDW-1:0] rr_ptr;

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            rr_ptr <= '0;
        end else if (ack_fire) begin
            rr_ptr <= (irq_id == IDW'(NSRC-1)) ? '0 : irq_id + 1'b1;
        end
    end

    // Rotating search starting just after the last granted source.
    always_comb begin
        logic found;
        int   idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < NSRC; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IDW'(i);
        end
    end
`endif

    always_comb begin
        state_next = state;
        id_next    = irq_id;
        case (state)
            ST_IDLE: begin
                if (any_eligible) begin
                    id_next    = winner;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!eligible[irq_id]) state_next = ST_IDLE;
                else if (irq_ack)      state_next = ST_SVC;
            end
            ST_SVC: begin
                if (eoi_hit) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            state     <= ST_IDLE;
            irq_id    <= '0;
            irq_valid <= 1'b0;
        end else begin
            state     <= state_next;
            irq_id    <= id_next;
            irq_valid <= (state_next == ST_REQ);
        end
    end

    always_comb begin
        rdata_next = '0;
        case (csr_addr)
            ADDR_ENABLE:   rdata_next = 32'(enable);
            ADDR_MODE:     rdata_next = 32'(mode);
            ADDR_POLARITY: rdata_next = 32'(polarity);
            ADDR_PENDING:  rdata_next = 32'(pending);
            ADDR_STATUS: begin
                rdata_next[0]          = irq_valid;
                rdata_next[1]          = (state == ST_SVC);
                rdata_next[8 +: IDW]   = irq_id;
            end
            default: rdata_next = '0;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!core_rstn)  csr_rdata <= '0;
        else if (csr_re) csr_rdata <= rdata_next;
    end

endmodule

`default_nettype wire

// File: tb/tb_mgmt_irq_arbiter.sv
// Scoreboard bench for mgmt_irq_arbiter: expected CSR reads and irq_valid
// transitions are queued by the stimulus and checked by an independent monitor.
`default_nettype none

module tb_mgmt_irq_arbiter;

    localparam int NSRC = 8;
    localparam int IDW  = 3;

    localparam logic [2:0] A_ENABLE = 3'd0;
    localparam logic [2:0] A_MODE   = 3'd1;
    localparam logic [2:0] A_POL    = 3'd2;
    localparam logic [2:0] A_PEND   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_EOI    = 3'd5;

    logic            core_clk = 1'b0;
    logic            core_rstn;
    logic [NSRC-1:0] irq_src;
    logic            csr_we, csr_re, irq_ack;
    logic [2:0]      csr_addr;
    logic [31:0]     csr_wdata;
    logic [31:0]     csr_rdata;
    logic            irq_valid;
    logic [IDW-1:0]  irq_id;

    mgmt_irq_arbiter #(.NSRC(NSRC), .IDW(IDW), .SYNC_STAGES(2)) dut (
        .core_clk  (core_clk),
        .core_rstn (core_rstn),
        .irq_src   (irq_src),
        .csr_we    (csr_we),
        .csr_re    (csr_re),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        bit          rise;
        logic [2:0]  id;
        int          cyc;
    } ev_t;

    typedef struct {
        string       nm;
        logic [31:0] val;
        logic [31:0] mask;
    } rd_t;

    ev_t  ev_q[$];
    rd_t  rd_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic re_s    = 1'b0;
    logic prev_v;
    bit   mon_en  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge core_clk) begin
        cyc  <= cyc + 1;
        re_s <= csr_re;
    end

    // Monitor: read data the cycle after csr_re, and every irq_valid transition.
    always @(negedge core_clk) begin
        if (mon_en) begin
            if (re_s) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", csr_rdata, 32'hDEAD_BEEF);
                end else begin
                    rd_t r;
                    r = rd_q.pop_front();
                    check(r.nm, csr_rdata & r.mask, r.val & r.mask);
                end
            end
            if (irq_valid !== prev_v) begin
                if (ev_q.size() == 0) begin
                    check("unexpected_valid_change", 32'(irq_valid), 32'(prev_v));
                end else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    check("valid_edge_dir", 32'(irq_valid), 32'(e.rise));
                    if (e.rise) check("grant_id", 32'(irq_id), 32'(e.id));
                    if (e.cyc >= 0) check("edge_cycle", cyc, e.cyc);
                end
            end
        end
        prev_v = irq_valid;
    end

    task automatic tick();
        @(negedge core_clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] e,
                      input logic [31:0] m);
        rd_t r;
        r.nm = nm; r.val = e; r.mask = m;
        rd_q.push_back(r);
        csr_re = 1'b1; csr_addr = a;
        tick();
        csr_re = 1'b0;
    endtask

    task automatic exp_rise(input logic [2:0] id, input int c);
        ev_t e;
        e.rise = 1'b1; e.id = id; e.cyc = c;
        ev_q.push_back(e);
    endtask

    task automatic exp_fall(input int c);
        ev_t e;
        e.rise = 1'b0; e.id = '0; e.cyc = c;
        ev_q.push_back(e);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!irq_valid && n < 40) begin
            tick();
            n++;
        end
        if (!irq_valid) check({nm, "_timeout"}, 32'(irq_valid), 32'd1);
    endtask

    task automatic ack();
        exp_fall(cyc + 1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        logic [2:0] second_id;
        core_rstn = 1'b0; irq_src = 8'hFF; irq_ack = 1'b0;
        csr_we = 1'b0; csr_re = 1'b0; csr_addr = '0; csr_wdata = '0;
        repeat (5) tick();

        // Reset state
        core_rstn = 1'b1; irq_src = '0;
        mon_en = 1;
        check("reset_irq_valid", 32'(irq_valid), 32'd0);
        check("reset_irq_id", 32'(irq_id), 32'd0);
        check("reset_rdata", csr_rdata, 32'd0);
        rd("reset_status", A_STATUS, 32'h0, 32'hFFFF_FFFF);
        rd("reset_pending", A_PEND, 32'h0, 32'hFFFF_FFFF);
        rd("reset_enable", A_ENABLE, 32'h0, 32'hFFFF_FFFF);
        repeat (8) tick();

        // Edge latency, ack, mismatched and matching EOI
        wr(A_ENABLE, 32'h08);
        wr(A_MODE, 32'h08);
        irq_src = 8'h08;
        exp_rise(3'd3, cyc + 1 + 4);
        tick();
        irq_src = '0;
        wait_valid("edge_grant");
        ack();
        rd("edge_pending_cleared", A_PEND, 32'h0, 32'hFFFF_FFFF);
        rd("edge_status_svc", A_STATUS, 32'h0302, 32'hFFFF_FFFF);
        wr(A_EOI, 32'd2);
        rd("eoi_mismatch_stays_svc", A_STATUS, 32'h0302, 32'hFFFF_FFFF);
        wr(A_EOI, 32'd3);
        rd("eoi_match_idle", A_STATUS, 32'h0, 32'h3);

        // Priority between level sources 2 and 5
        wr(A_MODE, 32'h00);
        wr(A_ENABLE, 32'hFF);
        irq_src = 8'b0010_0100;
        exp_rise(3'd2, -1);
        wait_valid("prio_grant1");
        ack();
`ifdef IRQ_RR_ARB_EN
        second_id = 3'd5;
`else
        second_id = 3'd2;
`endif
        exp_rise(second_id, -1);
        wr(A_EOI, 32'd2);
        wait_valid("prio_grant2");
        ack();
        irq_src = '0;
        repeat (6) tick();
        wr(A_EOI, 32'(second_id));
        rd("prio_idle", A_STATUS, 32'h0, 32'h3);

        // Withdrawal of a level request by clearing its enable bit
        irq_src = 8'h40;
        exp_rise(3'd6, -1);
        wait_valid("withdraw_grant");
        exp_fall(cyc + 2);
        wr(A_ENABLE, 32'hBF);
        repeat (2) tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        repeat (3) tick();
        rd("withdraw_status_idle", A_STATUS, 32'h0, 32'h3);
        irq_src = '0;
        repeat (4) tick();

        // Edge set colliding with W1C on the same bit
        wr(A_ENABLE, 32'h00);
        wr(A_MODE, 32'h02);
        irq_src = 8'h02;
        repeat (3) tick();
        wr(A_PEND, 32'h02);
        rd("collision_set_wins", A_PEND, 32'h02, 32'hFFFF_FFFF);
        wr(A_PEND, 32'h02);
        rd("w1c_clears", A_PEND, 32'h00, 32'hFFFF_FFFF);
        irq_src = '0;
        repeat (4) tick();

        // Unmapped address and polarity readback
        wr(3'd6, 32'hFFFF_FFFF);
        rd("unmapped_reads_zero", 3'd6, 32'h0, 32'hFFFF_FFFF);
        wr(A_MODE, 32'h00);
        wr(A_POL, 32'h80);
        rd("polarity_rb", A_POL, 32'h80, 32'hFFFF_FFFF);

        // Mid-service reset
        wr(A_ENABLE, 32'h10);
        irq_src = 8'h10;
        exp_rise(3'd4, -1);
        wait_valid("svc_grant");
        ack();
        rd("svc_status", A_STATUS, 32'h0402, 32'hFFFF_FFFF);
        core_rstn = 1'b0; irq_src = '0;
        tick();
        core_rstn = 1'b1;
        rd("rst_status", A_STATUS, 32'h0, 32'hFFFF_FFFF);
        rd("rst_enable", A_ENABLE, 32'h0, 32'hFFFF_FFFF);
        rd("rst_mode", A_MODE, 32'h0, 32'hFFFF_FFFF);
        rd("rst_polarity", A_POL, 32'h0, 32'hFFFF_FFFF);
        rd("rst_pending", A_PEND, 32'h0, 32'hFFFF_FFFF);
        repeat (5) tick();

        check("events_drained", 32'(ev_q.size()), 32'd0);
        check("reads_drained", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
